// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the 32:1 selector slice.
//   WIDTH_DEF : default data width of every input and of F
//   SEL_W     : select code width (five tree levels)
//   NUM_IN    : number of data inputs (2**SEL_W)
package mux_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int SEL_W     = 5;
  localparam int NUM_IN    = 32;
endpackage

// File: rtl/mux2to1.sv
// mux2to1: WIDTH-bit 2:1 selector, the leaf/node cell of the 32:1 tree.
//   a   : chosen when sel == 0
//   b   : chosen when sel == 1
//   sel : select bit
//   y   : selected data (purely combinational)
module mux2to1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  // ?: merges disagreeing bits to X when sel is X/Z, so unknowns propagate.
  assign y = sel ? b : a;
endmodule

// File: rtl/mux32to1.sv
// mux32to1: WIDTH-bit 32:1 selector built as a five-level mux2to1 tree.
//   clk, rst : clock / synchronous active-high reset; only used when the
//              output register is built, otherwise present for uniformity
//   S        : select code 0..31, F = In when S == n
//   I00..I31 : data inputs
//   F        : selected data
// Build option: define MUX32TO1_OUTREG_EN to register F on the rising clk
// edge (1-cycle latency, rst clears F to 0 and wins over capture).
module mux32to1 import mux_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] S,
  input  logic [WIDTH-1:0] I00, I01, I02, I03, I04, I05, I06, I07,
  input  logic [WIDTH-1:0] I08, I09, I10, I11, I12, I13, I14, I15,
  input  logic [WIDTH-1:0] I16, I17, I18, I19, I20, I21, I22, I23,
  input  logic [WIDTH-1:0] I24, I25, I26, I27, I28, I29, I30, I31,
  output logic [WIDTH-1:0] F
);
  logic [WIDTH-1:0] in_arr [NUM_IN];
  // Heap-ordered tree: node k has children 2k+1 / 2k+2, root is node 0,
  // leaves occupy NUM_IN-1 .. 2*NUM_IN-2 in input order. With this layout
  // the node at depth d steers on S[SEL_W-1-d], so S[0] sits just above
  // the leaves and S[4] at the root.
  logic [WIDTH-1:0] node [2*NUM_IN-1];
  logic [WIDTH-1:0] sel_f;

  assign in_arr = '{I00, I01, I02, I03, I04, I05, I06, I07,
                    I08, I09, I10, I11, I12, I13, I14, I15,
                    I16, I17, I18, I19, I20, I21, I22, I23,
                    I24, I25, I26, I27, I28, I29, I30, I31};

  for (genvar n = 0; n < NUM_IN; n++) begin : g_leaf
    assign node[NUM_IN-1+n] = in_arr[n];
  end

  for (genvar d = 0; d < SEL_W; d++) begin : g_lvl
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      localparam int K = (1 << d) - 1 + j;
      mux2to1 #(.WIDTH(WIDTH)) u_mux (
        .a   (node[2*K+1]),
        .b   (node[2*K+2]),
        .sel (S[SEL_W-1-d]),
        .y   (node[K])
      );
    end
  end

  assign sel_f = node[0];

`ifdef MUX32TO1_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) F <= '0;
    else     F <= sel_f;
  end
`else
  assign F = sel_f;
  // clk/rst intentionally have no function in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};
`endif
endmodule

// File: tb/tb_mux32to1.sv
// tb_mux32to1: randomized + directed bench for mux32to1 (WIDTH = 64).
// A reference model (array indexing din[S], plus a one-cycle delay with
// reset clearing when MUX32TO1_OUTREG_EN is defined) is compared against F
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_mux32to1;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   sel;
  logic [W-1:0] din [32];
  logic [W-1:0] F;
  logic [W-1:0] exp_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux32to1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .S(sel),
    .I00(din[0]),  .I01(din[1]),  .I02(din[2]),  .I03(din[3]),
    .I04(din[4]),  .I05(din[5]),  .I06(din[6]),  .I07(din[7]),
    .I08(din[8]),  .I09(din[9]),  .I10(din[10]), .I11(din[11]),
    .I12(din[12]), .I13(din[13]), .I14(din[14]), .I15(din[15]),
    .I16(din[16]), .I17(din[17]), .I18(din[18]), .I19(din[19]),
    .I20(din[20]), .I21(din[21]), .I22(din[22]), .I23(din[23]),
    .I24(din[24]), .I25(din[25]), .I26(din[26]), .I27(din[27]),
    .I28(din[28]), .I29(din[29]), .I30(din[30]), .I31(din[31]),
    .F(F)
  );

  // Registered-build reference: what F must hold after each rising edge.
  always @(posedge clk) exp_q <= rst ? '0 : din[sel];

  function automatic logic [W-1:0] model();
`ifdef MUX32TO1_OUTREG_EN
    return exp_q;
`else
    return din[sel];
`endif
  endfunction

  // Inputs only change at negedge+1, so they are stable here.
  always @(negedge clk) begin
    total++;
    if (F !== model()) begin
      bad++;
      $display("FAIL model S=%0d got=%h exp=%h", sel, F, model());
    end
  end

  task automatic chk(input string name, input logic [W-1:0] want);
    total++;
    if (F !== want) begin
      bad++;
      $display("FAIL %s S=%0d got=%h exp=%h", name, sel, F, want);
    end
  endtask

  // One full cycle; returns at negedge+1 so the caller may check then drive.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lit_exp(input int s);
    case (s)
      10:      return 64'd19;
      14:      return 64'd60;
      18:      return 64'd20;
      21:      return 64'd8;
      28:      return 64'd21;
      30:      return 64'd30;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] rst_exp(input logic [W-1:0] v);
`ifdef MUX32TO1_OUTREG_EN
    return 64'd0;
`else
    return v;
`endif
  endfunction

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    rst = 1'b1;
    sel = 5'd10;
    for (int n = 0; n < 32; n++) din[n] = '0;
    din[10] = 64'd19; din[14] = 64'd60; din[18] = 64'd20;
    din[21] = 64'd8;  din[28] = 64'd21; din[30] = 64'd30;

    // Reset held for two edges, then released, then reasserted mid-run.
    settle();
    settle();
    chk("rst_hold", rst_exp(64'd19));
    rst = 1'b0;
    settle();
    chk("rst_release", 64'd19);
    sel = 5'd14;
    rst = 1'b1;
    settle();
    chk("rst_mid", rst_exp(64'd60));
    rst = 1'b0;
    settle();
    chk("rst_after", 64'd60);

    // Sweep every select code over the sparse pattern.
    for (int s = 0; s < 32; s++) begin
      sel = 5'(s);
      settle();
      chk("sweep", lit_exp(s));
    end

    // In = n+1: extreme codes.
    for (int n = 0; n < 32; n++) din[n] = 64'(n + 1);
    sel = 5'd31;
    settle();
    chk("sel31", 64'd32);
    sel = 5'd0;
    settle();
    chk("sel0", 64'd1);

    // Neighbours of the selected input must not leak through.
    sel = 5'd5;
    din[5] = 64'hA5A5_5A5A_0F0F_F0F0;
    for (int t = 0; t < 4; t++) begin
      din[6] = t[0] ? ones : '0;
      din[4] = t[0] ? '0 : ones;
      settle();
      chk("isolate", 64'hA5A5_5A5A_0F0F_F0F0);
    end

    // Walking one across all 64 bits of the selected input.
    sel = 5'd17;
    for (int b = 0; b < W; b++) begin
      din[17] = 64'd1 << b;
      settle();
      chk("walk1", 64'd1 << b);
    end

    // Random selects, data and occasional reset pulses.
    for (int n = 0; n < 32; n++) din[n] = {$urandom, $urandom};
    for (int i = 0; i < 300; i++) begin
      sel = 5'($urandom_range(0, 31));
      din[$urandom_range(0, 31)] = {$urandom, $urandom};
      din[sel] = {$urandom, $urandom};
      rst = ($urandom_range(0, 15) == 0);
      settle();
    end
    rst = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux32to1.md
MUX32TO1 -- requirements
Module: mux32to1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the data width of every input and of F.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-004 The block SHALL have port S, input, 5 bits: the select code, unsigned 0..31.
REQ-005 The block SHALL have ports I00..I31, each an input of WIDTH bits: data input n, chosen when S == n.
REQ-006 The block SHALL have port F, output, WIDTH bits: the selected data.

Function
REQ-007 F SHALL equal In when S == n, for every n in 0..31; all 32 codes are legal and there is no default or invalid case.
REQ-008 In the base build, F SHALL be purely combinational, with zero-cycle latency from any change on S or on the selected In.
REQ-009 A change on any non-selected input SHALL NOT affect F.
REQ-010 F SHALL be bit-exact for all WIDTH bits, with no sign extension, truncation or arithmetic.
REQ-011 Each time S changes, F SHALL follow the new selection with no intermediate dependence on the previous S.
REQ-012 If S or the selected input contains X or Z, F SHALL propagate X in simulation; there is no defined recovery value.
REQ-013 The block SHALL NOT contain latches in either build.

Reset
REQ-014 In the base build, rst and clk SHALL have no effect on F; the ports exist for interface uniformity.
REQ-015 With MUX32TO1_OUTREG_EN defined, rst high at a rising clk edge SHALL set F to 0 on that edge.
REQ-016 With MUX32TO1_OUTREG_EN defined, rst SHALL take priority over the capture of new data on the same edge.
REQ-017 With MUX32TO1_OUTREG_EN defined, asserting rst mid-operation SHALL discard the pending selection; the next non-reset edge captures the current S and In.

Configuration
REQ-018 The macro MUX32TO1_OUTREG_EN SHALL select output registering.
REQ-019 With MUX32TO1_OUTREG_EN undefined, F SHALL be combinational as in REQ-008.
REQ-020 With MUX32TO1_OUTREG_EN defined, F SHALL be registered on the rising clk edge, with exactly 1-cycle latency from S/In to F.
REQ-021 With MUX32TO1_OUTREG_EN defined, F SHALL be 0 from reset until the first non-reset edge.
REQ-022 With MUX32TO1_OUTREG_EN defined, the registered value SHALL equal the combinational selection sampled at that edge.

Structure
REQ-023 A shared package mux_pkg SHALL hold: the default WIDTH (64), SEL_W = 5 and NUM_IN = 32.
REQ-024 The selection SHALL be built as a tree of the sub-module mux2to1 (WIDTH-parameterised, 2:1), five levels deep, with S[0] at the leaf level and S[4] at the root.
REQ-025 The mux2to1 tree SHALL be generated with a generate loop, not hand-instantiated.
REQ-026 The optional output register SHALL sit at the top level only.

Verification
REQ-027 Bench SHALL load all inputs with 0 except I10=19, I14=60, I18=20, I21=8, I28=21 and I30=30.
REQ-028 Scenario: step S through 0..31 -> F = 19 at S=10, 60 at 14, 20 at 18, 8 at 21, 21 at 28, 30 at 30, and 0 at every other code.
REQ-029 Scenario: set In = n+1 for every n, hold S = 31 -> F = 32; then S = 0 -> F = 1.
REQ-030 Scenario: hold S = 5, toggle I06 and I04 between all-ones and 0 -> F stays at I05 throughout.
REQ-031 Scenario: walking-ones pattern on the selected input I17 at S=17 -> F matches bit-exact on all 64 bits, including bit 63.
REQ-032 Scenario (MUX32TO1_OUTREG_EN): S=10 with rst high for 2 edges -> F = 0; after rst drops -> F = 19 one edge later; rst reasserted mid-sequence -> F = 0 on that edge.
